// File: rtl/shift_rx.sv
// shift_rx: LSB-first serial-to-parallel receiver with a one-entry output
// register, valid/ready hand-off and a sticky overrun flag.
module shift_rx #(
    parameter int WIDTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Bit_In,
    input  logic                     Bit_Valid,
    input  logic                     Frame_Start,
    input  logic                     Data_Ready,
    input  logic                     Overrun_Clr,
    output logic [WIDTH-1:0]         Data_Out,
    output logic                     Data_Valid,
    output logic                     Busy,
    output logic [$clog2(WIDTH)-1:0] Bit_Count,
    output logic                     Overrun
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic             overrun_q;

    logic [WIDTH-1:0] sr_d;
    logic [CW-1:0]    cnt_d;
    logic             wordDone;
    logic             loadOk;

    // A bit arriving with Frame_Start is bit 0 of a new word, so it never completes one.
    assign sr_d     = {Bit_In, sr_q[WIDTH-1:1]};
    assign wordDone = Bit_Valid && !Frame_Start && (cnt_q == LAST);
    assign loadOk   = wordDone && ((state_q == EMPTY) || Data_Ready);

    always_comb begin
        cnt_d = cnt_q;
        if (Frame_Start) begin
            cnt_d = Bit_Valid ? CW'(1) : '0;
        end else if (Bit_Valid) begin
            cnt_d = wordDone ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= EMPTY;
            sr_q      <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (Bit_Valid) begin
                sr_q <= sr_d;
            end

            case (state_q)
                EMPTY: begin
                    if (wordDone) begin
                        data_q  <= sr_d;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (loadOk) begin
                        data_q <= sr_d;
                    end else if (Data_Ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase

            // A drop outranks a clear landing on the same edge.
            if (wordDone && !loadOk) begin
                overrun_q <= 1'b1;
            end else if (Overrun_Clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign Data_Out   = data_q;
    assign Data_Valid = (state_q == FULL);
    assign Busy       = (cnt_q != '0);
    assign Bit_Count  = cnt_q;
    assign Overrun    = overrun_q;

endmodule

// File: tb/tb_shift_rx.sv
// tb_shift_rx: directed and randomized checks of shift_rx against a
// word-level reference model (bit positions, held word, overrun flag).
module tb_shift_rx;
    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Bit_In = 1'b0;
    logic         Bit_Valid = 1'b0;
    logic         Frame_Start = 1'b0;
    logic         Data_Ready = 1'b0;
    logic         Overrun_Clr = 1'b0;
    logic [W-1:0] Data_Out;
    logic         Data_Valid;
    logic         Busy;
    logic [2:0]   Bit_Count;
    logic         Overrun;

    int           checks = 0;
    int           errors = 0;

    // Reference model: bits land directly at their index in the word.
    int           mN = 0;
    logic [W-1:0] mPart = '0;
    logic [W-1:0] mHeld = '0;
    logic         mValid = 1'b0;
    logic         mOvr = 1'b0;

    shift_rx #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Bit_In     (Bit_In),
        .Bit_Valid  (Bit_Valid),
        .Frame_Start(Frame_Start),
        .Data_Ready (Data_Ready),
        .Overrun_Clr(Overrun_Clr),
        .Data_Out   (Data_Out),
        .Data_Valid (Data_Valid),
        .Busy       (Busy),
        .Bit_Count  (Bit_Count),
        .Overrun    (Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic modelReset();
        mN     = 0;
        mHeld  = '0;
        mValid = 1'b0;
        mOvr   = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (Data_Out === mHeld) else begin
            errors++;
            $error("[TB] FAIL %s data_out: observed %0h expected %0h", tag, Data_Out, mHeld);
        end
        checks++;
        assert (Data_Valid === mValid) else begin
            errors++;
            $error("[TB] FAIL %s data_valid: observed %0b expected %0b", tag, Data_Valid, mValid);
        end
        checks++;
        assert (Overrun === mOvr) else begin
            errors++;
            $error("[TB] FAIL %s overrun: observed %0b expected %0b", tag, Overrun, mOvr);
        end
        checks++;
        assert (Bit_Count === 3'(mN)) else begin
            errors++;
            $error("[TB] FAIL %s bit_count: observed %0d expected %0d", tag, Bit_Count, mN);
        end
        checks++;
        assert (Busy === (mN != 0)) else begin
            errors++;
            $error("[TB] FAIL %s busy: observed %0b expected %0b", tag, Busy, (mN != 0));
        end
    endtask

    task automatic applyStimulus(input logic bv, input logic bi, input logic fs,
                                 input logic rdy, input logic oclr, input string tag);
        logic loaded;
        logic drop;
        Bit_Valid   = bv;
        Bit_In      = bi;
        Frame_Start = fs;
        Data_Ready  = rdy;
        Overrun_Clr = oclr;

        loaded = 1'b0;
        drop   = 1'b0;
        if (fs) mN = 0;
        if (bv) begin
            mPart[mN] = bi;
            mN++;
            if (mN == W) begin
                mN = 0;
                if (!mValid || rdy) begin
                    mHeld  = mPart;
                    loaded = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        if (loaded) mValid = 1'b1;
        else if (mValid && rdy) mValid = 1'b0;
        if (drop) mOvr = 1'b1;
        else if (oclr) mOvr = 1'b0;

        @(posedge Clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic sendWord(input logic [W-1:0] word, input logic rdyAll,
                            input logic rdyLast, input logic clrLast, input string tag);
        for (int i = 0; i < W; i++) begin
            applyStimulus(1'b1, word[i], 1'b0, rdyAll || (rdyLast && i == W - 1),
                          clrLast && i == W - 1, tag);
        end
    endtask

    initial begin
        // Reset and idle
        #12;
        checkOutput("reset");
        Reset_n = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

        // Single word, then pop
        sendWord(8'hA5, 1'b0, 1'b0, 1'b0, "wordA5");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "holdA5");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "popA5");

        // Overrun, clear-vs-drop collision, then lone clear
        sendWord(8'h3C, 1'b0, 1'b0, 1'b0, "word3C");
        sendWord(8'hFF, 1'b0, 1'b0, 1'b0, "dropFF");
        sendWord(8'hF0, 1'b0, 1'b0, 1'b1, "dropClr");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovrClr");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pop3C");

        // Same-edge pop and load, then streaming
        sendWord(8'h7E, 1'b0, 1'b0, 1'b0, "word7E");
        sendWord(8'h81, 1'b0, 1'b1, 1'b0, "popLoad81");
        sendWord(8'h01, 1'b1, 1'b1, 1'b0, "stream01");
        sendWord(8'h02, 1'b1, 1'b1, 1'b0, "stream02");
        sendWord(8'h03, 1'b1, 1'b1, 1'b0, "stream03");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pop03");

        // Realign: 5 junk bits, Frame_Start with bit 0 = 1, 7 more bits of 0x55
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, "junk");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "realign");
        for (int i = 1; i < W; i++) applyStimulus(1'b1, 1'(i % 2 == 0), 1'b0, 1'b0, 1'b0, "word55");
        checks++;
        assert (Data_Out === 8'h55) else begin
            errors++;
            $error("[TB] FAIL realign_word: observed %0h expected 55", Data_Out);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "fsFull");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pop55");

        // Asynchronous reset mid-word while 0x99 is held
        sendWord(8'h99, 1'b0, 1'b0, 1'b0, "word99");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "partial");
        #2;
        Reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncReset");
        #2;
        Reset_n = 1'b1;
        sendWord(8'h12, 1'b0, 1'b0, 1'b0, "word12");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pop12");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
